// File: rtl/pipe_hazard_ctrl.sv
// Hazard/flush/hold sequencing controller for the 5-stage pipeline.
// Optional stall performance counter enabled by HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic [31:0]      IF_ID_IR,
  input  logic [31:0]      ID_EX_IR,
  input  logic [2:0]       ID_EX_type,
  input  logic             branch_taken,
  input  logic             ex_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             if_flush,
  output logic             cond_stage,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01,
    HOLD  = 2'b10,
    BAD   = 2'b11
  } state_t;

  state_t      r_state;
  logic [2:0]  r_flush_cnt;

  logic [6:0]  w_if_op;
  logic [4:0]  w_rd;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic        w_hz_lu;
  logic        w_unused_bits;

  assign w_if_op       = IF_ID_IR[6:0];
  assign w_rd          = ID_EX_IR[11:7];
  assign w_unused_bits = ^{IF_ID_IR[31:25], IF_ID_IR[14:7], ID_EX_IR[31:12]};

  always_comb begin
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_if_op)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: w_uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign w_hz_lu = (ID_EX_type == 3'b000) && (ID_EX_IR[6:0] == 7'b0000011) &&
                   (w_rd != 5'd0) &&
                   ((w_uses_rs1 && (IF_ID_IR[19:15] == w_rd)) ||
                    (w_uses_rs2 && (IF_ID_IR[24:20] == w_rd)));

  // Outputs decode from the registered state (plus hz_lu in RUN); reset overrides.
  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    id_ex_write = 1'b0;
    if_flush    = 1'b0;
    cond_stage  = 1'b0;
    if (!rst_n) begin
      if_flush   = 1'b1;
      cond_stage = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          pc_write    = !w_hz_lu;
          if_id_write = !w_hz_lu;
          id_ex_write = 1'b1;
          cond_stage  = w_hz_lu;
        end
        FLUSH: begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          id_ex_write = 1'b1;
          if_flush    = 1'b1;
          cond_stage  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = r_state;

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
    end else if (branch_taken) begin
      r_state     <= FLUSH;
      r_flush_cnt <= 3'(FLUSH_CYCLES - 1);
    end else begin
      case (r_state)
        FLUSH: begin
          if (r_flush_cnt == 3'd0) r_state <= RUN;
          else                     r_flush_cnt <= r_flush_cnt - 3'd1;
        end
        RUN:     if (ex_busy)  r_state <= HOLD;
        HOLD:    if (!ex_busy) r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if ((!pc_write || (r_state == FLUSH)) && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign stall_cycles = r_stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, CNT_W=4).
module tb_pipe_hazard_ctrl;

  logic        clk2;
  logic        rst_n;
  logic [31:0] IF_ID_IR;
  logic [31:0] ID_EX_IR;
  logic [2:0]  ID_EX_type;
  logic        branch_taken;
  logic        ex_busy;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_write;
  logic        if_flush;
  logic        cond_stage;
  logic [1:0]  state;
  logic [3:0]  stall_cycles;

  int unsigned n_checks;
  int unsigned n_errors;

  localparam logic [6:0] E_RST   = 7'b0001100;
  localparam logic [6:0] E_RUN   = 7'b1110000;
  localparam logic [6:0] E_STALL = 7'b0010100;
  localparam logic [6:0] E_FL    = 7'b1111101;
  localparam logic [6:0] E_HLD   = 7'b0000010;

  localparam logic [31:0] LW_X5   = 32'h0000A283; // lw  x5,0(x1)
  localparam logic [31:0] LW_X0   = 32'h0000A003; // lw  x0,0(x1)
  localparam logic [31:0] ADD_RS1 = 32'h00228333; // add x6,x5,x2
  localparam logic [31:0] ADD_RS2 = 32'h00500333; // add x6,x0,x5
  localparam logic [31:0] ADD_X0  = 32'h00200333; // add x6,x0,x2
  localparam logic [31:0] LUI_X6  = 32'h00528337; // lui x6,0x528 (rs fields = 5)

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk2         (clk2),
    .rst_n        (rst_n),
    .IF_ID_IR     (IF_ID_IR),
    .ID_EX_IR     (ID_EX_IR),
    .ID_EX_type   (ID_EX_type),
    .branch_taken (branch_taken),
    .ex_busy      (ex_busy),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .id_ex_write  (id_ex_write),
    .if_flush     (if_flush),
    .cond_stage   (cond_stage),
    .state        (state),
    .stall_cycles (stall_cycles)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    #1;
    obs = {pc_write, if_id_write, id_ex_write, if_flush, cond_stage, state};
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] exp);
    n_checks++;
    assert (stall_cycles === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, stall_cycles, exp);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    IF_ID_IR     = '0;
    ID_EX_IR     = '0;
    ID_EX_type   = 3'b111;
    branch_taken = 1'b1;
    ex_busy      = 1'b0;

    // Reset with branch_taken held high
    repeat (3) tick();
    chk("reset_outputs", E_RST);
    chk_cnt("reset_cnt", 4'd0);
    rst_n = 1'b1; branch_taken = 1'b0;
    chk("release_comb", E_RUN);
    tick();
    chk("run_idle", E_RUN);

    // Load-use hazards
    ID_EX_IR = LW_X5; ID_EX_type = 3'b000; IF_ID_IR = ADD_RS1;
    chk("lu_rs1_stall", E_STALL);
    tick();
    ID_EX_IR = '0;
    chk("lu_bubble_clears", E_RUN);
    ID_EX_IR = LW_X5; IF_ID_IR = ADD_RS2;
    chk("lu_rs2_stall", E_STALL);
    ID_EX_IR = LW_X0; IF_ID_IR = ADD_X0;
    chk("lu_rd_x0", E_RUN);
    ID_EX_IR = LW_X5; IF_ID_IR = LUI_X6;
    chk("lu_lui_no_rs", E_RUN);
    IF_ID_IR = ADD_RS1; ID_EX_type = 3'b001;
    chk("lu_not_load_type", E_RUN);
    IF_ID_IR = '0; ID_EX_IR = '0; ID_EX_type = 3'b111;
    tick();

    // Branch flush: exactly two cycles
    branch_taken = 1'b1;
    chk("br_before_edge", E_RUN);
    tick(); branch_taken = 1'b0;
    chk("br_flush_c1", E_FL);
    tick();
    chk("br_flush_c2", E_FL);
    tick();
    chk("br_back_run", E_RUN);

    // Second pulse during flush cycle 2 restarts the squash
    branch_taken = 1'b1;
    tick(); branch_taken = 1'b0;
    chk("br2_c1", E_FL);
    tick(); branch_taken = 1'b1;
    chk("br2_c2", E_FL);
    tick(); branch_taken = 1'b0;
    chk("br2_c3", E_FL);
    tick();
    chk("br2_c4", E_FL);
    tick();
    chk("br2_run", E_RUN);

    // Hold for 4 cycles of ex_busy
    ex_busy = 1'b1;
    chk("hold_before_edge", E_RUN);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) ex_busy = 1'b0;
      chk("hold_cycle", E_HLD);
    end
    tick();
    chk("hold_exit", E_RUN);

    // Branch during HOLD, busy still high after flush
    ex_busy = 1'b1;
    tick();
    chk("hold2_enter", E_HLD);
    branch_taken = 1'b1;
    tick(); branch_taken = 1'b0;
    chk("hold2_br_flush1", E_FL);
    tick();
    chk("hold2_br_flush2", E_FL);
    tick();
    chk("hold2_run_gap", E_RUN);
    tick();
    chk("hold2_rehold", E_HLD);
    ex_busy = 1'b0;
    tick();
    chk("hold2_exit", E_RUN);

    // Priority: branch over busy over load-use
    branch_taken = 1'b1; ex_busy = 1'b1;
    ID_EX_IR = LW_X5; ID_EX_type = 3'b000; IF_ID_IR = ADD_RS1;
    chk("prio_same_cycle", E_STALL);
    tick(); branch_taken = 1'b0;
    chk("prio_flush1_hz_ignored", E_FL);
    tick();
    chk("prio_flush2", E_FL);
    tick();
    chk("prio_run_hz", E_STALL);
    tick();
    chk("prio_hold", E_HLD);
    ex_busy = 1'b0; IF_ID_IR = '0; ID_EX_IR = '0; ID_EX_type = 3'b111;
    tick();
    chk("prio_exit", E_RUN);

    // Reset aborts FLUSH with no leftover counter
    branch_taken = 1'b1;
    tick(); branch_taken = 1'b0;
    chk("rstfl_flush", E_FL);
    rst_n = 1'b0;
    chk("rstfl_async", E_RST);
    tick(); rst_n = 1'b1;
    chk("rstfl_release", E_RUN);
    tick();
    chk("rstfl_no_residual", E_RUN);

    // Reset aborts HOLD
    ex_busy = 1'b1;
    tick();
    chk("rsthd_hold", E_HLD);
    rst_n = 1'b0;
    chk("rsthd_async", E_RST);
    ex_busy = 1'b0;
    tick(); rst_n = 1'b1;
    chk("rsthd_release", E_RUN);
    tick();
    chk("rsthd_run", E_RUN);

    // Performance counter
`ifdef HAZ_PERF_CNT_EN
    chk_cnt("cnt_after_reset", 4'd0);
    branch_taken = 1'b1;
    tick(); branch_taken = 1'b0;
    tick(); tick();
    chk_cnt("cnt_flush2", 4'd2);
    ex_busy = 1'b1;
    repeat (21) tick();
    chk_cnt("cnt_saturated", 4'd15);
    ex_busy = 1'b0;
    tick();
`else
    ex_busy = 1'b1;
    repeat (21) tick();
    chk_cnt("cnt_disabled", 4'd0);
    ex_busy = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
